// File: rtl/robot_controller.sv
// Wall-following trash-collecting robot controller: left-hand wall follower with
// multi-cycle right-rotation and trash-removal sequences and a spin watchdog.
module robot_controller #(
  parameter int REMOVE_CYCLES = 3,
  parameter int SPIN_LIMIT    = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic front,
  output logic turn,
  output logic remove
);

  localparam int              SW       = $clog2(SPIN_LIMIT + 1);
  localparam logic [1:0]      REM_INIT = 2'(REMOVE_CYCLES - 1);
  localparam logic [1:0]      ROT_INIT = 2'd2;
  localparam logic [SW-1:0]   SPIN_MAX = SW'(SPIN_LIMIT);
  localparam logic [SW-1:0]   SPIN_ONE = SW'(1);

  typedef enum logic [2:0] {
    SEARCH,
    FOLLOW,
    FWD_AFTER_LEFT,
    ROT_RIGHT,
    REMOVE,
    REMOVE_WAIT,
    STOP
  } state_e;

  state_e          state_q, state_d, rule;
  logic [1:0]      rem_cnt_q, rem_cnt_d;
  logic [1:0]      rot_cnt_q, rot_cnt_d;
  logic [SW-1:0]   spin_q, spin_d;
  logic            front_q, front_d;
  logic            turn_q, turn_d;
  logic            remove_q, remove_d;
  logic            decide;

  always_comb begin
    state_d   = state_q;
    rem_cnt_d = rem_cnt_q;
    rot_cnt_d = rot_cnt_q;
    spin_d    = spin_q;
    front_d   = 1'b0;
    turn_d    = 1'b0;
    remove_d  = 1'b0;
    decide    = 1'b0;
    rule      = state_q;

    // Sequencing states either continue their scripted outputs or fall
    // through to a FOLLOW decision on their final edge.
    case (state_q)
      SEARCH, FOLLOW, FWD_AFTER_LEFT: decide = 1'b1;
      ROT_RIGHT: begin
        if (rot_cnt_q != 2'd0) begin
          turn_d    = 1'b1;
          rot_cnt_d = rot_cnt_q - 2'd1;
        end else begin
          decide = 1'b1;
          rule   = FOLLOW;
        end
      end
      REMOVE: begin
        if (rem_cnt_q != 2'd0) begin
          remove_d  = 1'b1;
          rem_cnt_d = rem_cnt_q - 2'd1;
        end else begin
          state_d = REMOVE_WAIT;
        end
      end
      REMOVE_WAIT: begin
        decide = 1'b1;
        rule   = FOLLOW;
      end
      default: ;
    endcase

    if (decide) begin
      if (under) begin
        state_d = STOP;
      end else if (barrier) begin
        state_d   = REMOVE;
        remove_d  = 1'b1;
        rem_cnt_d = REM_INIT;
      end else begin
        case (rule)
          SEARCH: begin
            if (!head && !left) front_d = 1'b1;
            else                state_d = FOLLOW;
          end
          FWD_AFTER_LEFT: begin
            front_d = !head;
            state_d = FOLLOW;
          end
          default: begin
            if (!left) begin
              turn_d  = 1'b1;
              state_d = FWD_AFTER_LEFT;
            end else if (!head) begin
              front_d = 1'b1;
              state_d = FOLLOW;
            end else if (spin_q == SPIN_MAX) begin
              state_d = STOP;
            end else begin
              // 270-degree left rotation stands in for a right turn
              turn_d    = 1'b1;
              rot_cnt_d = ROT_INIT;
              spin_d    = spin_q + SPIN_ONE;
              state_d   = ROT_RIGHT;
            end
          end
        endcase
      end
    end

    if (front_d) spin_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= SEARCH;
      rem_cnt_q <= '0;
      rot_cnt_q <= '0;
      spin_q    <= '0;
      front_q   <= 1'b0;
      turn_q    <= 1'b0;
      remove_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_cnt_q <= rem_cnt_d;
      rot_cnt_q <= rot_cnt_d;
      spin_q    <= spin_d;
      front_q   <= front_d;
      turn_q    <= turn_d;
      remove_q  <= remove_d;
    end
  end

  assign front  = front_q;
  assign turn   = turn_q;
  assign remove = remove_q;

endmodule

// File: tb/tb_robot_controller.sv
// Directed vector table plus randomized run of three parameterizations checked
// against an action-script reference model.
module tb_robot_controller;

  logic clock = 1'b0;
  logic reset, head, left, under, barrier;
  logic [2:0] f, t, r;

  always #5 clock = ~clock;

  robot_controller #(.REMOVE_CYCLES(3), .SPIN_LIMIT(4)) u_dut0 (
    .clock(clock), .reset(reset), .head(head), .left(left), .under(under),
    .barrier(barrier), .front(f[0]), .turn(t[0]), .remove(r[0]));
  robot_controller #(.REMOVE_CYCLES(1), .SPIN_LIMIT(1)) u_dut1 (
    .clock(clock), .reset(reset), .head(head), .left(left), .under(under),
    .barrier(barrier), .front(f[1]), .turn(t[1]), .remove(r[1]));
  robot_controller #(.REMOVE_CYCLES(4), .SPIN_LIMIT(2)) u_dut2 (
    .clock(clock), .reset(reset), .head(head), .left(left), .under(under),
    .barrier(barrier), .front(f[2]), .turn(t[2]), .remove(r[2]));

  // output encoding {front, turn, remove}
  localparam logic [2:0] O_F = 3'b100, O_T = 3'b010, O_R = 3'b001, O_0 = 3'b000;

  typedef struct packed {
    logic [1:0]  mode;     // 0 search, 1 follow, 2 after a left turn
    logic        stopped;
    logic [7:0]  spins;
    logic [23:0] plan;     // queued per-cycle outputs, 3 bits each
    logic [3:0]  plen;
  } mst_t;

  mst_t ms[3];
  int   rc[3] = '{3, 1, 4};
  int   sl[3] = '{4, 1, 2};
  logic [2:0] mo[3];

  int nvec = 0;
  int nerr = 0;

  function automatic void push(inout mst_t s, input logic [2:0] v);
    s.plan = s.plan | (24'(v) << (3 * s.plen));
    s.plen = s.plen + 4'd1;
  endfunction

  function automatic logic [2:0] mstep(inout mst_t s, input logic rs, h, l, u, b,
                                       input int rcy, input int slim);
    logic [2:0] o;
    if (!rs) begin
      s = '0;
      return O_0;
    end
    if (s.stopped) return O_0;
    if (s.plen == 0) begin
      if (u) begin
        s.stopped = 1'b1;
        return O_0;
      end else if (b) begin
        for (int i = 0; i < rcy; i++) push(s, O_R);
        push(s, O_0);
        s.mode = 2'd1;
      end else if (s.mode == 2'd0) begin
        if (!h && !l) push(s, O_F);
        else begin push(s, O_0); s.mode = 2'd1; end
      end else if (s.mode == 2'd2) begin
        push(s, h ? O_0 : O_F);
        s.mode = 2'd1;
      end else begin
        if (!l) begin
          push(s, O_T);
          s.mode = 2'd2;
        end else if (!h) begin
          push(s, O_F);
        end else if (int'(s.spins) >= slim) begin
          s.stopped = 1'b1;
          return O_0;
        end else begin
          s.spins = s.spins + 8'd1;
          for (int i = 0; i < 3; i++) push(s, O_T);
        end
      end
    end
    o      = s.plan[2:0];
    s.plan = s.plan >> 3;
    s.plen = s.plen - 4'd1;
    if (o == O_F) s.spins = '0;
    return o;
  endfunction

  task automatic step(input logic rs, h, l, u, b);
    @(negedge clock);
    reset = rs; head = h; left = l; under = u; barrier = b;
    @(posedge clock);
    for (int k = 0; k < 3; k++) mo[k] = mstep(ms[k], rs, h, l, u, b, rc[k], sl[k]);
    #1;
  endtask

  typedef struct {
    logic rs, h, l, u, b;
    logic [2:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rs, h, l, u, b, input logic [2:0] e,
                              input string n);
    vec_t v;
    v.rs = rs; v.h = h; v.l = l; v.u = u; v.b = b; v.exp = e; v.name = n;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [2:0] got;
    reset = 1'b0; head = 1'b0; left = 1'b0; under = 1'b0; barrier = 1'b0;
    for (int k = 0; k < 3; k++) ms[k] = '0;

    add(0,0,0,0,0, O_0, "reset");      add(0,0,0,0,0, O_0, "reset");
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, O_F, "search_fwd");
    add(1,1,0,0,0, O_0, "search_to_follow");
    add(1,1,1,0,0, O_T, "rot1"); add(1,1,1,0,0, O_T, "rot2");
    add(1,0,1,0,0, O_T, "rot3_ignore"); add(1,0,1,0,0, O_F, "after_rot_fwd");
    for (int i = 0; i < 3; i++) add(1,1,1,0,1, O_R, "remove");
    add(1,1,1,0,1, O_0, "remove_wait"); add(1,0,1,0,0, O_F, "post_remove_fwd");
    add(1,0,0,0,0, O_T, "left_turn"); add(1,0,0,0,0, O_F, "fal_fwd");
    add(1,1,0,0,0, O_T, "left_turn2"); add(1,1,0,0,0, O_0, "fal_blocked");
    add(1,0,1,1,1, O_0, "under_over_barrier"); add(1,0,0,0,0, O_0, "stop_hold");
    add(0,0,0,0,0, O_0, "reset2"); add(1,1,1,0,0, O_0, "enclosed_enter");
    for (int i = 0; i < 12; i++) add(1,1,1,0,0, O_T, "enclosed_turn");
    add(1,1,1,0,0, O_0, "spin_stop"); add(1,0,0,0,0, O_0, "spin_stop_hold");
    add(0,0,0,0,0, O_0, "reset3");
    add(1,0,0,0,1, O_R, "search_remove"); add(1,0,0,0,1, O_R, "remove_2nd");
    add(0,0,0,0,1, O_0, "reset_mid_remove");
    add(1,0,0,0,0, O_F, "restart_fwd"); add(1,0,0,0,0, O_F, "restart_fwd2");
    add(1,1,0,0,0, O_0, "to_follow"); add(1,1,1,0,0, O_T, "rot_u1");
    add(1,1,1,1,0, O_T, "rot_u2"); add(1,1,1,1,0, O_T, "rot_u3");
    add(1,1,1,1,0, O_0, "under_after_rot");

    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].h, tbl[i].l, tbl[i].u, tbl[i].b);
      got = {f[0], t[0], r[0]};
      nvec++;
      if (got !== tbl[i].exp) begin
        nerr++;
        $display("FAIL %s vec %0d: got ftr=%b expected ftr=%b", tbl[i].name, i,
                 got, tbl[i].exp);
      end
    end

    step(0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      logic rs;
      rs = ($urandom_range(0, 59) != 0);
      step(rs, 1'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 7) == 0));
      for (int k = 0; k < 3; k++) begin
        got = {f[k], t[k], r[k]};
        nvec++;
        if (got !== mo[k]) begin
          nerr++;
          $display("FAIL rand dut%0d cyc %0d: got ftr=%b expected ftr=%b", k, n,
                   got, mo[k]);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/robot_controller.md
ROBOT_CONTROLLER -- requirements
Module: robot_controller

Interface
REQ-001 SHALL have parameter REMOVE_CYCLES, default 3: consecutive cycles remove is held to clear one trash cell.
REQ-002 SHALL have parameter SPIN_LIMIT, default 4: consecutive right-rotations without a forward step before the block stops.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 head  input  1  wall or map edge directly ahead.
REQ-006 left  input  1  wall or map edge on the robot's left.
REQ-007 under  input  1  robot is on the goal cell.
REQ-008 barrier  input  1  trash cell directly ahead.
REQ-009 front  output  1  step one cell forward this cycle.
REQ-010 turn  output  1  rotate 90 degrees counter-clockwise (left) this cycle.
REQ-011 remove  output  1  trash-removal request; the world clears the cell after REMOVE_CYCLES consecutive high cycles.

Function
REQ-012 front, turn and remove SHALL be registered outputs; at most one SHALL be high in any cycle.
REQ-013 Inputs SHALL be sampled on the rising edge; a decision taken at edge k SHALL drive outputs from edge k until edge k+1 (one-cycle latency).
REQ-014 States: SEARCH, FOLLOW, FWD_AFTER_LEFT, ROT_RIGHT, REMOVE, REMOVE_WAIT, STOP.
REQ-015 Decision priority in SEARCH, FOLLOW and FWD_AFTER_LEFT: under=1 -> STOP; else barrier=1 -> REMOVE; else the state-specific rule.
REQ-016 SEARCH rule: head=0 and left=0 -> front=1, stay in SEARCH; head=1 or left=1 -> all outputs 0, go to FOLLOW.
REQ-017 FOLLOW rule: left=0 -> turn=1, go to FWD_AFTER_LEFT; else head=0 -> front=1, stay in FOLLOW; else -> turn=1, go to ROT_RIGHT.
REQ-018 FWD_AFTER_LEFT rule: head=0 -> front=1, go to FOLLOW; head=1 -> all outputs 0, go to FOLLOW; left is ignored (prevents continuous spinning).
REQ-019 ROT_RIGHT SHALL hold turn=1 for exactly 3 consecutive cycles in total (a 270-degree left rotation equals a right turn), then return to FOLLOW with the outputs updated by the FOLLOW decision; inputs SHALL be ignored during the rotation.
REQ-020 REMOVE SHALL hold remove=1 for exactly REMOVE_CYCLES consecutive cycles, then go to REMOVE_WAIT; barrier and head SHALL be ignored during this count.
REQ-021 REMOVE_WAIT SHALL drive all outputs 0 for one cycle so the world can refresh its sensors, then go to FOLLOW.
REQ-022 A 2-bit removal counter SHALL count REMOVE_CYCLES-1 down to 0; REMOVE_CYCLES values of 1..4 SHALL be supported.
REQ-023 A spin counter of width clog2(SPIN_LIMIT+1) SHALL increment on each entry to ROT_RIGHT and clear whenever front=1 is issued; reaching SPIN_LIMIT SHALL force STOP instead of a further ROT_RIGHT.
REQ-024 STOP SHALL drive all outputs 0 and be left only by reset.
REQ-025 under=1 arriving during ROT_RIGHT or REMOVE SHALL NOT abort the sequence; it SHALL be acted on at the next decision point.
REQ-026 Simultaneous barrier=1 and head=1 SHALL select REMOVE (REQ-015 priority).

Reset
REQ-027 While reset=0 at a rising edge: state <= SEARCH, front=turn=remove=0, removal counter and spin counter <= 0.
REQ-028 Reset asserted mid-REMOVE or mid-ROT_RIGHT SHALL drop every output to 0 at that same edge; the partial sequence SHALL NOT resume.
REQ-029 The first decision SHALL occur at the first rising edge with reset=1.

Verification
REQ-030 Reset release with head=0, left=0, under=0, barrier=0 for 3 cycles -> front=1 on 3 consecutive cycles; turn=remove=0.
REQ-031 In FOLLOW, head=1, left=1 -> turn=1 for exactly 3 cycles, then front=1 one cycle later if head has become 0.
REQ-032 barrier=1 in FOLLOW -> remove=1 for 3 cycles, then 1 cycle with all outputs 0, then a FOLLOW decision; holding barrier=1 throughout does not extend remove beyond 3 cycles.
REQ-033 Enclosed cell (head=1, left=1 held constant) -> 4 ROT_RIGHT sequences (12 turn cycles), then STOP with all outputs 0 indefinitely.
REQ-034 under=1 with barrier=1 in FOLLOW -> STOP, all outputs 0; no remove pulse.
REQ-035 reset=0 asserted on the 2nd cycle of remove -> remove=0 at that edge; after release with head=0, left=0 -> front=1 from SEARCH.
